// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache controller with one-word lines.
// Read hits complete combinationally in IDLE; misses and writes go through a mem_req/mem_ack handshake.
module dm_cache_ctrl #(
  parameter int unsigned BIT_WIDTH  = 32,
  parameter int unsigned INDEX_BITS = 4,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 cpu_req,
  input  logic                 memwrite,
  input  logic [BIT_WIDTH-1:0] addr,
  input  logic [BIT_WIDTH-1:0] writedata,
  output logic [BIT_WIDTH-1:0] memdata,
  output logic                 cpu_ready,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [BIT_WIDTH-1:0] mem_addr,
  output logic [BIT_WIDTH-1:0] mem_wdata,
  input  logic [BIT_WIDTH-1:0] mem_rdata,
  input  logic                 mem_ack,
  output logic [CNT_WIDTH-1:0] hit_cnt,
  output logic [CNT_WIDTH-1:0] miss_cnt
);

  localparam int unsigned Lines   = 1 << INDEX_BITS;
  localparam int unsigned TagBits = BIT_WIDTH - INDEX_BITS;

  typedef enum logic [1:0] {StIdle, StFill, StWrite, StResp} state_e;

  state_e                 state_q;
  logic [BIT_WIDTH-1:0]   addr_q, wdata_q, resp_q;
  logic [Lines-1:0]       valid_q;
  logic [TagBits-1:0]     tag_q  [Lines];
  logic [BIT_WIDTH-1:0]   data_q [Lines];
  logic [CNT_WIDTH-1:0]   hit_cnt_q, miss_cnt_q;
  logic                   mem_req_q, mem_we_q;

  logic [INDEX_BITS-1:0]  req_idx, lat_idx;
  logic [TagBits-1:0]     req_tag, lat_tag;
  logic                   req_hit, lat_hit, rd_hit;

  assign req_idx = addr[INDEX_BITS-1:0];
  assign req_tag = addr[BIT_WIDTH-1:INDEX_BITS];
  assign lat_idx = addr_q[INDEX_BITS-1:0];
  assign lat_tag = addr_q[BIT_WIDTH-1:INDEX_BITS];
  assign req_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign lat_hit = valid_q[lat_idx] && (tag_q[lat_idx] == lat_tag);

  // Zero-latency read hit: only in IDLE, and never while reset or flush is being serviced.
  assign rd_hit = (state_q == StIdle) && !reset && !flush && cpu_req && !memwrite && req_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      valid_q    <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      resp_q     <= '0;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (flush) begin
            valid_q    <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
          end else if (cpu_req) begin
            if (memwrite) begin
              addr_q    <= addr;
              wdata_q   <= writedata;
              mem_req_q <= 1'b1;
              mem_we_q  <= 1'b1;
              state_q   <= StWrite;
            end else if (req_hit) begin
              if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + CNT_WIDTH'(1);
            end else begin
              addr_q    <= addr;
              mem_req_q <= 1'b1;
              mem_we_q  <= 1'b0;
              state_q   <= StFill;
              if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + CNT_WIDTH'(1);
            end
          end
        end
        StFill: begin
          if (mem_ack) begin
            valid_q[lat_idx] <= 1'b1;
            resp_q           <= mem_rdata;
            mem_req_q        <= 1'b0;
            state_q          <= StResp;
          end
        end
        StWrite: begin
          if (mem_ack) begin
            resp_q    <= '0;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            state_q   <= StResp;
          end
        end
        StResp: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Tag/data storage is never reset; the valid bits alone qualify it.
  always_ff @(posedge clk) begin
    if (!reset && mem_ack) begin
      if (state_q == StFill) begin
        data_q[lat_idx] <= mem_rdata;
        tag_q[lat_idx]  <= lat_tag;
      end else if (state_q == StWrite && lat_hit) begin
        data_q[lat_idx] <= wdata_q;
      end
    end
  end

  always_comb begin
    cpu_ready = 1'b0;
    memdata   = '0;
    if (rd_hit) begin
      cpu_ready = 1'b1;
      memdata   = data_q[req_idx];
    end else if (state_q == StResp && !reset) begin
      cpu_ready = 1'b1;
      memdata   = resp_q;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign hit_cnt   = hit_cnt_q;
  assign miss_cnt  = miss_cnt_q;

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Bench for dm_cache_ctrl: directed scenarios plus random traffic checked against a
// model that tracks backing memory contents and which address each line currently holds.
module tb_dm_cache_ctrl;

  localparam int unsigned W   = 32;
  localparam int unsigned IB  = 4;
  localparam int unsigned CW  = 2;

  logic          clk;
  logic          reset;
  logic          flush;
  logic          cpu_req;
  logic          memwrite;
  logic [W-1:0]  addr;
  logic [W-1:0]  writedata;
  logic [W-1:0]  memdata;
  logic          cpu_ready;
  logic          mem_req;
  logic          mem_we;
  logic [W-1:0]  mem_addr;
  logic [W-1:0]  mem_wdata;
  logic [W-1:0]  mem_rdata;
  logic          mem_ack;
  logic [CW-1:0] hit_cnt;
  logic [CW-1:0] miss_cnt;

  int total = 0;
  int bad   = 0;

  // Reference model: backing memory, and per-index the full address the line holds.
  logic [W-1:0] mem_m  [int unsigned];
  int unsigned  line_m [int unsigned];
  int           hits_m;
  int           misses_m;

  dm_cache_ctrl #(.BIT_WIDTH(W), .INDEX_BITS(IB), .CNT_WIDTH(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .cpu_req   (cpu_req),
    .memwrite  (memwrite),
    .addr      (addr),
    .writedata (writedata),
    .memdata   (memdata),
    .cpu_ready (cpu_ready),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  function automatic logic [W-1:0] mem_rd(input logic [W-1:0] a);
    if (mem_m.exists(a)) return mem_m[a];
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [CW-1:0] sat(input int n);
    int unsigned lim;
    lim = (1 << CW) - 1;
    return (n > int'(lim)) ? CW'(lim) : CW'(n);
  endfunction

  function automatic int unsigned idx_of(input logic [W-1:0] a);
    return a & ((1 << IB) - 1);
  endfunction

  task automatic model_clear();
    line_m.delete();
    hits_m   = 0;
    misses_m = 0;
  endtask

  // One CPU access with a memory responder acking after lat request cycles; checks against the model.
  task automatic run_op(input bit we, input logic [W-1:0] a, input logic [W-1:0] wd,
                        input int lat, output logic [W-1:0] rd);
    bit           exp_hit;
    logic [W-1:0] exp_data;
    int           n;
    bit           done;
    exp_hit  = !we && line_m.exists(idx_of(a)) && line_m[idx_of(a)] == a;
    exp_data = we ? '0 : mem_rd(a);
    rd       = '0;
    @(negedge clk);
    cpu_req = 1'b1; memwrite = we; addr = a; writedata = wd;
    #1;
    total++;
    if (cpu_ready !== exp_hit) begin
      bad++;
      $display("FAIL hit_now addr=%h got=%b want=%b", a, cpu_ready, exp_hit);
    end
    if (cpu_ready) begin
      rd = memdata;
      total++;
      if (mem_req !== 1'b0) begin
        bad++; $display("FAIL hit_mem_req addr=%h got=%b want=0", a, mem_req);
      end
      @(negedge clk);
      cpu_req = 1'b0;
    end else begin
      n = 0; done = 0;
      for (int c = 0; c < 40 && !done; c++) begin
        @(negedge clk);
        mem_ack = 1'b0;
        if (cpu_ready) begin
          rd = memdata;
          cpu_req = 1'b0;
          done = 1;
        end else if (mem_req) begin
          n++;
          total++;
          if (mem_addr !== a || mem_we !== we || (we && mem_wdata !== wd)) begin
            bad++;
            $display("FAIL mem_bus addr=%h got a=%h we=%b wd=%h want a=%h we=%b wd=%h",
                     a, mem_addr, mem_we, mem_wdata, a, we, wd);
          end
          if (n == lat) begin
            mem_ack = 1'b1;
            mem_rdata = we ? 32'hBAD0_BAD0 : mem_rd(a);
          end
        end
      end
      mem_ack = 1'b0;
      total++;
      if (!done) begin
        bad++; cpu_req = 1'b0;
        $display("FAIL timeout addr=%h got no cpu_ready want cpu_ready", a);
      end
      total++;
      if (n !== lat) begin
        bad++; $display("FAIL req_cycles addr=%h got=%0d want=%0d", a, n, lat);
      end
    end
    total++;
    if (rd !== exp_data) begin
      bad++; $display("FAIL memdata addr=%h we=%b got=%h want=%h", a, we, rd, exp_data);
    end
    if (we) mem_m[a] = wd;
    else if (exp_hit) hits_m++;
    else begin misses_m++; line_m[idx_of(a)] = a; end
    total++;
    if (hit_cnt !== sat(hits_m) || miss_cnt !== sat(misses_m)) begin
      bad++;
      $display("FAIL counters addr=%h got hit=%0d miss=%0d want hit=%0d miss=%0d",
               a, hit_cnt, miss_cnt, sat(hits_m), sat(misses_m));
    end
  endtask

  task automatic do_flush(input logic [W-1:0] a);
    @(negedge clk);
    flush = 1'b1; cpu_req = 1'b1; memwrite = 1'b0; addr = a;
    #1;
    total++;
    if (cpu_ready !== 1'b0) begin
      bad++; $display("FAIL flush_ready got=%b want=0", cpu_ready);
    end
    @(negedge clk);
    flush = 1'b0; cpu_req = 1'b0;
    model_clear();
    total++;
    if (hit_cnt !== '0 || miss_cnt !== '0) begin
      bad++; $display("FAIL flush_counters got hit=%0d miss=%0d want 0 0", hit_cnt, miss_cnt);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; cpu_req = 1'b0; memwrite = 1'b0;
    addr = '0; writedata = '0; mem_rdata = '0; mem_ack = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (cpu_ready !== 1'b0 || mem_req !== 1'b0 || mem_we !== 1'b0 || memdata !== '0) begin
      bad++;
      $display("FAIL reset_outputs got rdy=%b req=%b we=%b data=%h want 0 0 0 0",
               cpu_ready, mem_req, mem_we, memdata);
    end
    reset = 1'b0;
    @(negedge clk);
    model_clear();
    total++;
    if (hit_cnt !== '0 || miss_cnt !== '0 || mem_req !== 1'b0 || cpu_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_state got hit=%0d miss=%0d req=%b rdy=%b want 0 0 0 0",
               hit_cnt, miss_cnt, mem_req, cpu_ready);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] rd;
    mem_m[32'h10] = 32'hDEAD_BEEF;
    run_op(1'b0, 32'h10, '0, 3, rd);
    total++;
    if (rd !== 32'hDEAD_BEEF || miss_cnt !== 2'd1) begin
      bad++; $display("FAIL first_miss got data=%h miss=%0d want DEADBEEF 1", rd, miss_cnt);
    end
    run_op(1'b0, 32'h10, '0, 1, rd);
    total++;
    if (rd !== 32'hDEAD_BEEF || hit_cnt !== 2'd1) begin
      bad++; $display("FAIL first_hit got data=%h hit=%0d want DEADBEEF 1", rd, hit_cnt);
    end
    run_op(1'b1, 32'h10, 32'h1234_5678, 2, rd);
    run_op(1'b0, 32'h10, '0, 1, rd);
    total++;
    if (rd !== 32'h1234_5678) begin
      bad++; $display("FAIL write_through got=%h want 12345678", rd);
    end
    run_op(1'b1, 32'h20, 32'hCAFE_0020, 1, rd);
    run_op(1'b0, 32'h20, '0, 2, rd);
    run_op(1'b0, 32'h00, '0, 1, rd);
    run_op(1'b0, 32'h10, '0, 2, rd);
    run_op(1'b0, 32'h00, '0, 1, rd);
  endtask

  task automatic test_stray_ack();
    logic [W-1:0] rd;
    run_op(1'b0, 32'h2B, '0, 1, rd);
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_0000;
    @(negedge clk);
    mem_ack = 1'b0;
    total++;
    if (mem_req !== 1'b0 || cpu_ready !== 1'b0) begin
      bad++; $display("FAIL stray_ack got req=%b rdy=%b want 0 0", mem_req, cpu_ready);
    end
    run_op(1'b0, 32'h2B, '0, 1, rd);
  endtask

  task automatic test_reset_abort();
    logic [W-1:0] rd;
    int n;
    do_flush(32'h0);
    @(negedge clk);
    cpu_req = 1'b1; memwrite = 1'b0; addr = 32'h35;
    n = 0;
    for (int c = 0; c < 10 && n < 2; c++) begin
      @(negedge clk);
      if (mem_req) n++;
    end
    total++;
    if (n != 2) begin
      bad++; $display("FAIL abort_fill got req_cycles=%0d want 2", n);
    end
    reset = 1'b1; cpu_req = 1'b0;
    @(negedge clk);
    reset = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h0BAD_F00D;
    model_clear();
    total++;
    if (mem_req !== 1'b0 || cpu_ready !== 1'b0) begin
      bad++; $display("FAIL abort_req got req=%b rdy=%b want 0 0", mem_req, cpu_ready);
    end
    @(negedge clk);
    mem_ack = 1'b0;
    total++;
    if (mem_req !== 1'b0 || cpu_ready !== 1'b0 || hit_cnt !== '0 || miss_cnt !== '0) begin
      bad++;
      $display("FAIL abort_late_ack got req=%b rdy=%b hit=%0d miss=%0d want 0 0 0 0",
               mem_req, cpu_ready, hit_cnt, miss_cnt);
    end
    run_op(1'b0, 32'h35, '0, 2, rd);
  endtask

  task automatic test_saturate();
    logic [W-1:0] rd;
    do_flush(32'h7);
    run_op(1'b0, 32'h7, '0, 1, rd);
    for (int i = 0; i < 5; i++) run_op(1'b0, 32'h7, '0, 1, rd);
    total++;
    if (hit_cnt !== 2'd3) begin
      bad++; $display("FAIL hit_saturate got=%0d want 3", hit_cnt);
    end
    do_flush(32'h7);
    run_op(1'b0, 32'h7, '0, 1, rd);
    total++;
    if (hit_cnt !== 2'd0 || miss_cnt !== 2'd1) begin
      bad++; $display("FAIL after_flush got hit=%0d miss=%0d want 0 1", hit_cnt, miss_cnt);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] rd;
    int unsigned r;
    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(0, 99);
      if (r < 5) do_flush(W'($urandom_range(0, 47)));
      else run_op(r < 35, W'($urandom_range(0, 47)), $urandom, $urandom_range(1, 4), rd);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stray_ack();
    test_reset_abort();
    test_saturate();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
